// File: rtl/ysyx_23060061_axi4_rr_arbiter.sv
// N-master to 1-slave AXI4 arbiter: grants one whole read burst or write burst at a time,
// holding the grant until the final response, then re-arbitrates round-robin or fixed priority.
module ysyx_23060061_axi4_rr_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int ID_W        = 4,
    parameter bit RR_EN       = 1'b1,
    localparam int GW         = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
    localparam int SW         = DATA_W / 8
) (
    input  logic                        clk,
    input  logic                        rst,

    input  logic [NUM_MASTERS*ADDR_W-1:0] m_araddr,
    input  logic [NUM_MASTERS-1:0]        m_arvalid,
    input  logic [NUM_MASTERS*ID_W-1:0]   m_arid,
    input  logic [NUM_MASTERS*8-1:0]      m_arlen,
    input  logic [NUM_MASTERS*3-1:0]      m_arsize,
    input  logic [NUM_MASTERS*2-1:0]      m_arburst,
    output logic [NUM_MASTERS-1:0]        m_arready,
    output logic [NUM_MASTERS*DATA_W-1:0] m_rdata,
    output logic [NUM_MASTERS*2-1:0]      m_rresp,
    output logic [NUM_MASTERS-1:0]        m_rvalid,
    output logic [NUM_MASTERS-1:0]        m_rlast,
    output logic [NUM_MASTERS*ID_W-1:0]   m_rid,
    input  logic [NUM_MASTERS-1:0]        m_rready,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_awaddr,
    input  logic [NUM_MASTERS-1:0]        m_awvalid,
    input  logic [NUM_MASTERS*ID_W-1:0]   m_awid,
    input  logic [NUM_MASTERS*8-1:0]      m_awlen,
    input  logic [NUM_MASTERS*3-1:0]      m_awsize,
    input  logic [NUM_MASTERS*2-1:0]      m_awburst,
    output logic [NUM_MASTERS-1:0]        m_awready,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
    input  logic [NUM_MASTERS*SW-1:0]     m_wstrb,
    input  logic [NUM_MASTERS-1:0]        m_wvalid,
    input  logic [NUM_MASTERS-1:0]        m_wlast,
    output logic [NUM_MASTERS-1:0]        m_wready,
    output logic [NUM_MASTERS*2-1:0]      m_bresp,
    output logic [NUM_MASTERS-1:0]        m_bvalid,
    output logic [NUM_MASTERS*ID_W-1:0]   m_bid,
    input  logic [NUM_MASTERS-1:0]        m_bready,

    output logic [ADDR_W-1:0]             s_araddr,
    output logic                          s_arvalid,
    output logic [ID_W-1:0]               s_arid,
    output logic [7:0]                    s_arlen,
    output logic [2:0]                    s_arsize,
    output logic [1:0]                    s_arburst,
    input  logic                          s_arready,
    input  logic [DATA_W-1:0]             s_rdata,
    input  logic [1:0]                    s_rresp,
    input  logic                          s_rvalid,
    input  logic                          s_rlast,
    input  logic [ID_W-1:0]               s_rid,
    output logic                          s_rready,
    output logic [ADDR_W-1:0]             s_awaddr,
    output logic                          s_awvalid,
    output logic [ID_W-1:0]               s_awid,
    output logic [7:0]                    s_awlen,
    output logic [2:0]                    s_awsize,
    output logic [1:0]                    s_awburst,
    input  logic                          s_awready,
    output logic [DATA_W-1:0]             s_wdata,
    output logic [SW-1:0]                 s_wstrb,
    output logic                          s_wvalid,
    output logic                          s_wlast,
    input  logic                          s_wready,
    input  logic [1:0]                    s_bresp,
    input  logic                          s_bvalid,
    input  logic [ID_W-1:0]               s_bid,
    output logic                          s_bready,

    output logic [GW-1:0]                 grant_id,
    output logic                          busy
);

    typedef enum logic [1:0] {IDLE, GRANT_RD, GRANT_WR} state_t;

    state_t                 state;
    logic [GW-1:0]          g;
    logic [GW-1:0]          p;
    logic [NUM_MASTERS-1:0] req;
    logic                   found;
    logic [GW-1:0]          winner;
    logic [GW-1:0]          next_p;
    logic                   done;

    assign req      = m_arvalid | m_awvalid;
    assign grant_id = g;
    assign next_p   = (int'(g) == NUM_MASTERS - 1) ? '0 : g + 1'b1;
    assign done     = (state == GRANT_RD && s_rvalid && s_rready && s_rlast) ||
                      (state == GRANT_WR && s_bvalid && s_bready);

    // Cyclic search starting at p; with fixed priority the search always starts at 0.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            int idx;
            idx = RR_EN ? (int'(p) + k) % NUM_MASTERS : k;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = GW'(idx);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            g     <= '0;
            p     <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        g     <= winner;
                        busy  <= 1'b1;
                        state <= m_arvalid[winner] ? GRANT_RD : GRANT_WR;
                    end
                end
                GRANT_RD, GRANT_WR: begin
                    if (done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (RR_EN) p <= next_p;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: every output gets a zero default before the case so no path leaves it
    // unassigned; that is what keeps this combinational block from inferring latches.
    always_comb begin
        s_araddr  = '0; s_arvalid = 1'b0; s_arid  = '0; s_arlen = '0; s_arsize = '0;
        s_arburst = '0; s_rready  = 1'b0;
        s_awaddr  = '0; s_awvalid = 1'b0; s_awid  = '0; s_awlen = '0; s_awsize = '0;
        s_awburst = '0; s_wdata   = '0;   s_wstrb = '0; s_wvalid = 1'b0; s_wlast = 1'b0;
        s_bready  = 1'b0;
        m_arready = '0; m_rdata  = '0; m_rresp = '0; m_rvalid = '0; m_rlast = '0; m_rid = '0;
        m_awready = '0; m_wready = '0; m_bresp = '0; m_bvalid = '0; m_bid   = '0;
        case (state)
            GRANT_RD: begin
                s_araddr                     = m_araddr[g*ADDR_W +: ADDR_W];
                s_arvalid                    = m_arvalid[g];
                s_arid                       = m_arid[g*ID_W +: ID_W];
                s_arlen                      = m_arlen[g*8 +: 8];
                s_arsize                     = m_arsize[g*3 +: 3];
                s_arburst                    = m_arburst[g*2 +: 2];
                m_arready[g]                 = s_arready;
                m_rdata[g*DATA_W +: DATA_W]  = s_rdata;
                m_rresp[g*2 +: 2]            = s_rresp;
                m_rvalid[g]                  = s_rvalid;
                m_rlast[g]                   = s_rlast;
                m_rid[g*ID_W +: ID_W]        = s_rid;
                s_rready                     = m_rready[g];
            end
            GRANT_WR: begin
                s_awaddr                     = m_awaddr[g*ADDR_W +: ADDR_W];
                s_awvalid                    = m_awvalid[g];
                s_awid                       = m_awid[g*ID_W +: ID_W];
                s_awlen                      = m_awlen[g*8 +: 8];
                s_awsize                     = m_awsize[g*3 +: 3];
                s_awburst                    = m_awburst[g*2 +: 2];
                m_awready[g]                 = s_awready;
                s_wdata                      = m_wdata[g*DATA_W +: DATA_W];
                s_wstrb                      = m_wstrb[g*SW +: SW];
                s_wvalid                     = m_wvalid[g];
                s_wlast                      = m_wlast[g];
                m_wready[g]                  = s_wready;
                m_bresp[g*2 +: 2]            = s_bresp;
                m_bvalid[g]                  = s_bvalid;
                m_bid[g*ID_W +: ID_W]        = s_bid;
                s_bready                     = m_bready[g];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ysyx_23060061_axi4_rr_arbiter.sv
// Directed bench: a round-robin instance and a fixed-priority instance (3 masters, 64-bit data)
// share master and slave stimulus; the fixed-priority one is held in reset outside its own test.
module tb_ysyx_23060061_axi4_rr_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int IW = 4;
    localparam int GW = 2;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    logic rst;
    logic rst_fp;
    always #5 clk = ~clk;

    logic [N*AW-1:0] m_araddr, m_awaddr;
    logic [N-1:0]    m_arvalid, m_awvalid, m_wvalid, m_wlast, m_rready, m_bready;
    logic [N*IW-1:0] m_arid, m_awid;
    logic [N*8-1:0]  m_arlen, m_awlen;
    logic [N*3-1:0]  m_arsize, m_awsize;
    logic [N*2-1:0]  m_arburst, m_awburst;
    logic [N*DW-1:0] m_wdata;
    logic [N*SW-1:0] m_wstrb;

    logic          s_arready, s_rvalid, s_rlast, s_awready, s_wready, s_bvalid;
    logic [DW-1:0] s_rdata;
    logic [1:0]    s_rresp, s_bresp;
    logic [IW-1:0] s_rid, s_bid;

    logic [N-1:0]    rr_m_arready, rr_m_rvalid, rr_m_rlast, rr_m_awready, rr_m_wready, rr_m_bvalid;
    logic [N*DW-1:0] rr_m_rdata;
    logic [N*2-1:0]  rr_m_rresp, rr_m_bresp;
    logic [N*IW-1:0] rr_m_rid, rr_m_bid;
    logic [AW-1:0]   rr_s_araddr, rr_s_awaddr;
    logic            rr_s_arvalid, rr_s_rready, rr_s_awvalid, rr_s_wvalid, rr_s_wlast, rr_s_bready;
    logic [IW-1:0]   rr_s_arid, rr_s_awid;
    logic [7:0]      rr_s_arlen, rr_s_awlen;
    logic [2:0]      rr_s_arsize, rr_s_awsize;
    logic [1:0]      rr_s_arburst, rr_s_awburst;
    logic [DW-1:0]   rr_s_wdata;
    logic [SW-1:0]   rr_s_wstrb;
    logic [GW-1:0]   rr_grant_id;
    logic            rr_busy;

    logic [N-1:0]    fp_m_arready, fp_m_rvalid, fp_m_rlast, fp_m_awready, fp_m_wready, fp_m_bvalid;
    logic [N*DW-1:0] fp_m_rdata;
    logic [N*2-1:0]  fp_m_rresp, fp_m_bresp;
    logic [N*IW-1:0] fp_m_rid, fp_m_bid;
    logic [AW-1:0]   fp_s_araddr, fp_s_awaddr;
    logic            fp_s_arvalid, fp_s_rready, fp_s_awvalid, fp_s_wvalid, fp_s_wlast, fp_s_bready;
    logic [IW-1:0]   fp_s_arid, fp_s_awid;
    logic [7:0]      fp_s_arlen, fp_s_awlen;
    logic [2:0]      fp_s_arsize, fp_s_awsize;
    logic [1:0]      fp_s_arburst, fp_s_awburst;
    logic [DW-1:0]   fp_s_wdata;
    logic [SW-1:0]   fp_s_wstrb;
    logic [GW-1:0]   fp_grant_id;
    logic            fp_busy;

    ysyx_23060061_axi4_rr_arbiter #(
        .NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .RR_EN(1'b1)
    ) u_rr (
        .clk(clk), .rst(rst),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arid(m_arid), .m_arlen(m_arlen),
        .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arready(rr_m_arready),
        .m_rdata(rr_m_rdata), .m_rresp(rr_m_rresp), .m_rvalid(rr_m_rvalid), .m_rlast(rr_m_rlast),
        .m_rid(rr_m_rid), .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awid(m_awid), .m_awlen(m_awlen),
        .m_awsize(m_awsize), .m_awburst(m_awburst), .m_awready(rr_m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wlast(m_wlast),
        .m_wready(rr_m_wready), .m_bresp(rr_m_bresp), .m_bvalid(rr_m_bvalid), .m_bid(rr_m_bid),
        .m_bready(m_bready),
        .s_araddr(rr_s_araddr), .s_arvalid(rr_s_arvalid), .s_arid(rr_s_arid), .s_arlen(rr_s_arlen),
        .s_arsize(rr_s_arsize), .s_arburst(rr_s_arburst), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rlast(s_rlast), .s_rid(s_rid),
        .s_rready(rr_s_rready),
        .s_awaddr(rr_s_awaddr), .s_awvalid(rr_s_awvalid), .s_awid(rr_s_awid), .s_awlen(rr_s_awlen),
        .s_awsize(rr_s_awsize), .s_awburst(rr_s_awburst), .s_awready(s_awready),
        .s_wdata(rr_s_wdata), .s_wstrb(rr_s_wstrb), .s_wvalid(rr_s_wvalid), .s_wlast(rr_s_wlast),
        .s_wready(s_wready), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bid(s_bid),
        .s_bready(rr_s_bready),
        .grant_id(rr_grant_id), .busy(rr_busy)
    );

    ysyx_23060061_axi4_rr_arbiter #(
        .NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .RR_EN(1'b0)
    ) u_fp (
        .clk(clk), .rst(rst_fp),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arid(m_arid), .m_arlen(m_arlen),
        .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arready(fp_m_arready),
        .m_rdata(fp_m_rdata), .m_rresp(fp_m_rresp), .m_rvalid(fp_m_rvalid), .m_rlast(fp_m_rlast),
        .m_rid(fp_m_rid), .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awid(m_awid), .m_awlen(m_awlen),
        .m_awsize(m_awsize), .m_awburst(m_awburst), .m_awready(fp_m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wlast(m_wlast),
        .m_wready(fp_m_wready), .m_bresp(fp_m_bresp), .m_bvalid(fp_m_bvalid), .m_bid(fp_m_bid),
        .m_bready(m_bready),
        .s_araddr(fp_s_araddr), .s_arvalid(fp_s_arvalid), .s_arid(fp_s_arid), .s_arlen(fp_s_arlen),
        .s_arsize(fp_s_arsize), .s_arburst(fp_s_arburst), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rlast(s_rlast), .s_rid(s_rid),
        .s_rready(fp_s_rready),
        .s_awaddr(fp_s_awaddr), .s_awvalid(fp_s_awvalid), .s_awid(fp_s_awid), .s_awlen(fp_s_awlen),
        .s_awsize(fp_s_awsize), .s_awburst(fp_s_awburst), .s_awready(s_awready),
        .s_wdata(fp_s_wdata), .s_wstrb(fp_s_wstrb), .s_wvalid(fp_s_wvalid), .s_wlast(fp_s_wlast),
        .s_wready(s_wready), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bid(s_bid),
        .s_bready(fp_s_bready),
        .grant_id(fp_grant_id), .busy(fp_busy)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Snapshot of the instance under test, so the read helper serves both policies.
    logic          smp_busy, smp_sar, smp_saw;
    logic [GW-1:0] smp_gid;
    logic [N-1:0]  smp_arr, smp_awr, smp_rv;

    task automatic sample(input bit fp);
        if (fp) begin
            smp_busy = fp_busy; smp_sar = fp_s_arvalid; smp_saw = fp_s_awvalid; smp_gid = fp_grant_id;
            smp_arr = fp_m_arready; smp_awr = fp_m_awready; smp_rv = fp_m_rvalid;
        end else begin
            smp_busy = rr_busy; smp_sar = rr_s_arvalid; smp_saw = rr_s_awvalid; smp_gid = rr_grant_id;
            smp_arr = rr_m_arready; smp_awr = rr_m_awready; smp_rv = rr_m_rvalid;
        end
    endtask

    task automatic clear_inputs();
        m_araddr = '0; m_arvalid = '0; m_arid = '0; m_arlen = '0; m_arsize = '0; m_arburst = '0;
        m_awaddr = '0; m_awvalid = '0; m_awid = '0; m_awlen = '0; m_awsize = '0; m_awburst = '0;
        m_wdata = '0; m_wstrb = '0; m_wvalid = '0; m_wlast = '0;
        m_rready = '1; m_bready = '1;
        s_arready = 1'b1; s_awready = 1'b1; s_wready = 1'b1;
        s_rdata = '0; s_rresp = '0; s_rvalid = 1'b0; s_rlast = 1'b0; s_rid = '0;
        s_bresp = '0; s_bvalid = 1'b0; s_bid = '0;
    endtask

    task automatic reset_all();
        clear_inputs();
        rst = 1'b0;
        rst_fp = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
    endtask

    // Idle bubble, grant, AR handshake, one R beat with rlast; returns in the following IDLE cycle.
    task automatic run_read(input int exp_g, input bit fp, input bit drop);
        logic [N-1:0] onehot;
        onehot = '0;
        onehot[exp_g] = 1'b1;
        #1;
        sample(fp);
        check("rd_idle_busy", smp_busy, 0);
        cyc();
        sample(fp);
        check("rd_grant_id", smp_gid, exp_g);
        check("rd_busy", smp_busy, 1);
        check("rd_s_arvalid", smp_sar, 1);
        check("rd_s_awvalid", smp_saw, 0);
        check("rd_m_arready", smp_arr, onehot);
        check("rd_m_awready", smp_awr, 0);
        cyc();
        if (drop) m_arvalid[exp_g] = 1'b0;
        s_rvalid = 1'b1;
        s_rlast  = 1'b1;
        s_rdata  = 64'hD0 + 64'(exp_g);
        #1;
        sample(fp);
        check("rd_m_rvalid", smp_rv, onehot);
        cyc();
        s_rvalid = 1'b0;
        s_rlast  = 1'b0;
    endtask

    task automatic run_write(input int exp_g, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input logic [SW-1:0] strb, input int bdelay, input logic [1:0] resp);
        logic [N-1:0] onehot;
        onehot = '0;
        onehot[exp_g] = 1'b1;
        #1;
        check("wr_idle_busy", rr_busy, 0);
        cyc();
        check("wr_grant_id", rr_grant_id, exp_g);
        check("wr_s_awvalid", rr_s_awvalid, 1);
        check("wr_s_arvalid", rr_s_arvalid, 0);
        check("wr_s_awaddr", rr_s_awaddr, addr);
        check("wr_s_wdata", rr_s_wdata, data);
        check("wr_s_wstrb", rr_s_wstrb, strb);
        check("wr_s_wvalid", rr_s_wvalid, 1);
        check("wr_s_wlast", rr_s_wlast, 1);
        check("wr_m_awready", rr_m_awready, onehot);
        check("wr_m_wready", rr_m_wready, onehot);
        check("wr_m_arready", rr_m_arready, 0);
        cyc();
        m_awvalid[exp_g] = 1'b0;
        m_wvalid[exp_g]  = 1'b0;
        for (int i = 0; i < bdelay; i++) begin
            #1;
            check("wr_hold_busy", rr_busy, 1);
            check("wr_hold_bvalid", rr_m_bvalid, 0);
            cyc();
        end
        s_bvalid = 1'b1;
        s_bresp  = resp;
        s_bid    = 4'h7;
        #1;
        check("wr_m_bvalid", rr_m_bvalid, onehot);
        check("wr_m_bresp", rr_m_bresp[exp_g*2 +: 2], resp);
        check("wr_m_bid", rr_m_bid[exp_g*IW +: IW], 4'h7);
        check("wr_s_bready", rr_s_bready, 1);
        cyc();
        s_bvalid = 1'b0;
        s_bresp  = '0;
        #1;
        check("wr_release_busy", rr_busy, 0);
    endtask

    initial begin
        // Reset with every master requesting: nothing may leak out.
        clear_inputs();
        rst = 1'b0;
        rst_fp = 1'b0;
        m_arvalid = '1;
        m_awvalid = '1;
        m_wvalid  = '1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("rst_busy", rr_busy, 0);
            check("rst_grant_id", rr_grant_id, 0);
            check("rst_s_arvalid", rr_s_arvalid, 0);
            check("rst_s_awvalid", rr_s_awvalid, 0);
            check("rst_m_arready", rr_m_arready, 0);
            check("rst_m_awready", rr_m_awready, 0);
            check("rst_m_wready", rr_m_wready, 0);
        end
        rst = 1'b1;
        #1;
        check("rst_release_busy", rr_busy, 0);
        check("rst_release_arvalid", rr_s_arvalid, 0);
        cyc();
        check("rst_first_grant_busy", rr_busy, 1);
        check("rst_first_grant_id", rr_grant_id, 0);
        check("rst_first_grant_rd", rr_s_arvalid, 1);
        check("rst_first_grant_wr", rr_s_awvalid, 0);

        // Four-beat burst read from master 1.
        reset_all();
        m_arvalid[1]          = 1'b1;
        m_arlen[1*8 +: 8]     = 8'd3;
        m_araddr[1*AW +: AW]  = 32'h0000_1000;
        m_arid[1*IW +: IW]    = 4'h5;
        #1;
        check("burst_idle_busy", rr_busy, 0);
        cyc();
        check("burst_grant_id", rr_grant_id, 1);
        check("burst_s_arvalid", rr_s_arvalid, 1);
        check("burst_s_araddr", rr_s_araddr, 32'h0000_1000);
        check("burst_s_arlen", rr_s_arlen, 3);
        check("burst_s_arid", rr_s_arid, 4'h5);
        cyc();
        m_arvalid[1] = 1'b0;
        for (int b = 0; b < 4; b++) begin
            s_rvalid = 1'b1;
            s_rdata  = 64'hA0 + 64'(b);
            s_rlast  = (b == 3);
            s_rid    = 4'h5;
            #1;
            check("burst_rdata", rr_m_rdata[1*DW +: DW], 64'hA0 + 64'(b));
            check("burst_rlast", rr_m_rlast[1], (b == 3));
            check("burst_rid", rr_m_rid[1*IW +: IW], 4'h5);
            check("burst_m0_rvalid", rr_m_rvalid[0], 0);
            check("burst_m1_rvalid", rr_m_rvalid[1], 1);
            check("burst_busy", rr_busy, 1);
            cyc();
        end
        s_rvalid = 1'b0;
        s_rlast  = 1'b0;
        #1;
        check("burst_release_busy", rr_busy, 0);

        // Round-robin: three masters with continuous single-beat reads.
        reset_all();
        m_arvalid = '1;
        for (int i = 0; i < 6; i++) run_read(i % 3, 1'b0, 1'b0);

        // Fixed priority: masters 0 and 1 request continuously, only master 0 is served.
        reset_all();
        rst_fp = 1'b1;
        m_arvalid[1:0] = 2'b11;
        for (int i = 0; i < 3; i++) run_read(0, 1'b1, 1'b0);
        rst_fp = 1'b0;

        // 64-bit write with a delayed SLVERR response.
        reset_all();
        m_awvalid[0]          = 1'b1;
        m_awaddr[0*AW +: AW]  = 32'h8000_0008;
        m_wvalid[0]           = 1'b1;
        m_wlast[0]            = 1'b1;
        m_wdata[0*DW +: DW]   = 64'h1122_3344_5566_7788;
        m_wstrb[0*SW +: SW]   = 8'hFF;
        run_write(0, 32'h8000_0008, 64'h1122_3344_5566_7788, 8'hFF, 5, 2'd2);

        // With p=1: master 1 read, then master 0 read, then master 1 write.
        reset_all();
        m_arvalid[0] = 1'b1;
        run_read(0, 1'b0, 1'b1);
        m_arvalid[0]          = 1'b1;
        m_arvalid[1]          = 1'b1;
        m_awvalid[1]          = 1'b1;
        m_awaddr[1*AW +: AW]  = 32'h0000_2000;
        m_wvalid[1]           = 1'b1;
        m_wlast[1]            = 1'b1;
        m_wdata[1*DW +: DW]   = 64'hCAFE_F00D_0000_0001;
        m_wstrb[1*SW +: SW]   = 8'h0F;
        run_read(1, 1'b0, 1'b1);
        run_read(0, 1'b0, 1'b1);
        run_write(1, 32'h0000_2000, 64'hCAFE_F00D_0000_0001, 8'h0F, 0, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
